// File: rtl/function8bit_bist.sv
// Exhaustive self-test driver/checker for the registered 8-input boolean function block:
// sweeps all 256 vectors, realigns a golden tag pipeline to the block's latency and scores y.
module function8bit_bist #(
    parameter int LATENCY   = 1,
    parameter int ERR_CNT_W = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           vec_out,
    input  logic                 dut_y,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [7:0]           first_fail_vec,
    output logic                 first_fail_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [2:0] DRAIN_LAST = 3'(LATENCY - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_drain_cnt;
    logic [LATENCY-1:0]   r_tag_valid;
    logic [LATENCY-1:0]   r_tag_exp;
    logic [7:0]           r_tag_vec [LATENCY];

    logic                 w_exp;
    logic                 w_mismatch;
    logic                 w_start_sweep;
    logic                 w_err_sat;

    assign w_exp = ((vec_out[7] & vec_out[6]) | vec_out[5])
                 ^ ((vec_out[4] & vec_out[3]) | vec_out[2])
                 ^ (vec_out[1] & vec_out[0]);

    assign w_mismatch    = r_tag_valid[LATENCY-1] && (dut_y != r_tag_exp[LATENCY-1]);
    assign w_start_sweep = (r_state == ST_IDLE) && start;
    assign w_err_sat     = (err_count == {ERR_CNT_W{1'b1}});

    assign busy = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done = (r_state == ST_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the next state gets a default first, so no path through this block can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_RUN;
            ST_RUN:   if (vec_out == 8'hFF) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt == DRAIN_LAST) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the tag pipeline is reset with the rest of the state; an abort must leave no stale valid tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out          <= 8'd0;
            r_drain_cnt      <= 3'd0;
            r_tag_valid      <= '0;
            r_tag_exp        <= '0;
            for (int i = 0; i < LATENCY; i++) r_tag_vec[i] <= 8'd0;
            err_count        <= '0;
            first_fail_vec   <= 8'd0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else begin
            if (w_start_sweep) begin
                vec_out <= 8'd0;
            end else if (r_state == ST_RUN && vec_out != 8'hFF) begin
                vec_out <= vec_out + 8'd1;
            end

            if (r_state == ST_RUN) begin
                r_drain_cnt <= 3'd0;
            end else if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 3'd1;
            end

            for (int i = LATENCY - 1; i > 0; i--) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_exp[i]   <= r_tag_exp[i-1];
                r_tag_vec[i]   <= r_tag_vec[i-1];
            end
            r_tag_valid[0] <= (r_state == ST_RUN);
            r_tag_exp[0]   <= w_exp;
            r_tag_vec[0]   <= vec_out;
            if (w_start_sweep) r_tag_valid <= '0;

            if (w_start_sweep) begin
                err_count        <= '0;
                first_fail_valid <= 1'b0;
                pass             <= 1'b0;
            end else begin
                if (w_mismatch && !w_err_sat) err_count <= err_count + 1'b1;
                if (w_mismatch && !first_fail_valid) begin
                    first_fail_vec   <= r_tag_vec[LATENCY-1];
                    first_fail_valid <= 1'b1;
                end
                // The final compare lands in the last DRAIN cycle, so fold it in directly.
                if (r_state == ST_DRAIN && w_state_nxt == ST_DONE) begin
                    pass <= (err_count == '0) && !w_mismatch;
                end
            end
        end
    end

endmodule

// File: tb/tb_function8bit_bist.sv
// Bench for function8bit_bist: two instances (LATENCY=1/ERR_CNT_W=9 and LATENCY=2/ERR_CNT_W=4),
// each looped through a modelled function block whose y can be corrupted on purpose.
module tb_function8bit_bist;

    typedef enum int {M_OK, M_ZERO, M_ONE, M_INV, M_EXTRA} mode_t;

    typedef struct {
        int         err;
        logic       pass;
        logic [7:0] ffv;
        logic       ffval;
        int         done_idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    logic       busy_a, done_a, pass_a, ffval_a, y_a;
    logic [7:0] vec_a, ffv_a;
    logic [8:0] err_a;
    logic       busy_b, done_b, pass_b, ffval_b, y_b;
    logic [7:0] vec_b, ffv_b;
    logic [3:0] err_b;

    mode_t mode_a, mode_b;
    logic  y1_a, y2_a, y1_b, y2_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    logic       busy_s [2];
    logic       done_s [2];
    logic [7:0] vec_s  [2];
    logic       pass_s [2];
    logic [8:0] err_s  [2];
    logic [7:0] ffv_s  [2];
    logic       ffval_s[2];
    logic       prev_busy[2];
    int         start_cyc[2];

    function8bit_bist #(.LATENCY(1), .ERR_CNT_W(9)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a), .done(done_a),
        .vec_out(vec_a), .dut_y(y_a), .pass(pass_a), .err_count(err_a),
        .first_fail_vec(ffv_a), .first_fail_valid(ffval_a)
    );

    function8bit_bist #(.LATENCY(2), .ERR_CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_b), .done(done_b),
        .vec_out(vec_b), .dut_y(y_b), .pass(pass_b), .err_count(err_b),
        .first_fail_vec(ffv_b), .first_fail_valid(ffval_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic gold(input logic [7:0] v);
        logic a, b, c, d, e, f, g, h;
        {a, b, c, d, e, f, g, h} = v;
        return ((a & b) | c) ^ ((d & e) | f) ^ (g & h);
    endfunction

    // Function block stand-ins: one register for instance a, two registers for instance b.
    always @(posedge clk) begin
        y1_a <= gold(vec_a);
        y2_a <= y1_a;
        y1_b <= gold(vec_b);
        y2_b <= y1_b;
    end

    always_comb begin
        y_a = y1_a;
        case (mode_a)
            M_ZERO:  y_a = 1'b0;
            M_ONE:   y_a = 1'b1;
            M_INV:   y_a = ~y1_a;
            M_EXTRA: y_a = y2_a;
            default: y_a = y1_a;
        endcase
        y_b = y2_b;
        case (mode_b)
            M_ZERO:  y_b = 1'b0;
            M_ONE:   y_b = 1'b1;
            M_INV:   y_b = ~y2_b;
            default: y_b = y2_b;
        endcase
    end

    assign busy_s[0] = busy_a;   assign busy_s[1] = busy_b;
    assign done_s[0] = done_a;   assign done_s[1] = done_b;
    assign vec_s[0]  = vec_a;    assign vec_s[1]  = vec_b;
    assign pass_s[0] = pass_a;   assign pass_s[1] = pass_b;
    assign err_s[0]  = err_a;    assign err_s[1]  = {5'd0, err_b};
    assign ffv_s[0]  = ffv_a;    assign ffv_s[1]  = ffv_b;
    assign ffval_s[0] = ffval_a; assign ffval_s[1] = ffval_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Sweep-level reference: which of the 256 compares miss, given what y the block returns.
    function automatic exp_t model(input mode_t m, input int lat, input logic [7:0] prev, input int w);
        exp_t r;
        int   cnt = 0;
        logic seen;
        r.ffv   = 8'd0;
        r.ffval = 1'b0;
        for (int k = 0; k < 256; k++) begin
            case (m)
                M_ZERO:  seen = 1'b0;
                M_ONE:   seen = 1'b1;
                M_INV:   seen = ~gold(8'(k));
                M_EXTRA: seen = (k == 0) ? gold(prev) : gold(8'(k - 1));
                default: seen = gold(8'(k));
            endcase
            if (seen != gold(8'(k))) begin
                cnt++;
                if (!r.ffval) begin
                    r.ffv   = 8'(k);
                    r.ffval = 1'b1;
                end
            end
        end
        r.err      = (cnt > (1 << w) - 1) ? (1 << w) - 1 : cnt;
        r.pass     = (cnt == 0);
        r.done_idx = 257 + lat;
        return r;
    endfunction

    // Per-cycle monitor: vector walk, busy window, and scoreboard pop on each done pulse.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            automatic int   lat  = (d == 0) ? 1 : 2;
            automatic int   idx  = 0;
            automatic logic have = 1'b0;
            automatic exp_t e;
            if (!rst_n) begin
                prev_busy[d] <= 1'b0;
                start_cyc[d] <= 0;
            end else begin
                if (busy_s[d] && !prev_busy[d]) begin
                    idx = 1;
                    start_cyc[d] <= cyc;
                end else begin
                    idx = cyc - start_cyc[d] + 1;
                end
                if (busy_s[d]) begin
                    check($sformatf("vec_walk[%0d]", d), 32'(vec_s[d]), (idx <= 256) ? 32'(idx - 1) : 32'hFF);
                    check($sformatf("busy_window[%0d]", d), 32'(idx <= 256 + lat), 32'd1);
                end
                if (prev_busy[d] && !busy_s[d]) begin
                    check($sformatf("done_after_busy[%0d]", d), 32'(done_s[d]), 32'd1);
                end
                if (done_s[d]) begin
                    if (d == 0) begin
                        have = (q_a.size() != 0);
                        if (have) e = q_a.pop_front();
                    end else begin
                        have = (q_b.size() != 0);
                        if (have) e = q_b.pop_front();
                    end
                    check($sformatf("done_expected[%0d]", d), 32'(have), 32'd1);
                    if (have) begin
                        check($sformatf("done_cycle[%0d]", d), 32'(idx), 32'(e.done_idx));
                        check($sformatf("err_count[%0d]", d), 32'(err_s[d]), 32'(e.err));
                        check($sformatf("pass[%0d]", d), 32'(pass_s[d]), 32'(e.pass));
                        check($sformatf("ff_valid[%0d]", d), 32'(ffval_s[d]), 32'(e.ffval));
                        if (e.ffval) check($sformatf("ff_vec[%0d]", d), 32'(ffv_s[d]), 32'(e.ffv));
                    end
                end
                prev_busy[d] <= busy_s[d];
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_a || busy_b || done_a || done_b) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 1000), 32'd1);
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        while (!done_s[d] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("done_timeout[%0d]", d), 32'(n < 1000), 32'd1);
    endtask

    task automatic sweep(input mode_t ma, input mode_t mb, input logic [7:0] prev_a);
        mode_a = ma;
        mode_b = mb;
        q_a.push_back(model(ma, 1, prev_a, 9));
        q_b.push_back(model(mb, 2, 8'hFF, 4));
        pulse_start();
        wait_idle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        mode_a = M_OK;
        mode_b = M_OK;
        repeat (3) @(negedge clk);
        check("reset_a", 32'({busy_a, done_a, vec_a, pass_a, err_a, ffv_a, ffval_a}), 32'd0);
        check("reset_b", 32'({busy_b, done_b, vec_b, pass_b, err_b, ffv_b, ffval_b}), 32'd0);
        rst_n = 1'b1;

        // Clean sweep; a burst of start mid-run must not disturb the walk or the done timing.
        mode_a = M_OK;
        mode_b = M_OK;
        q_a.push_back(model(M_OK, 1, 8'h00, 9));
        q_b.push_back(model(M_OK, 2, 8'h00, 4));
        pulse_start();
        repeat (100) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("hold_pass_a", 32'({pass_a, err_a, ffval_a}), 32'({1'b1, 9'd0, 1'b0}));
        check("hold_pass_b", 32'({pass_b, err_b, ffval_b}), 32'({1'b1, 4'd0, 1'b0}));

        sweep(M_ZERO, M_ZERO, 8'hFF);
        check("zero_err_a", 32'(err_a), 32'd124);
        check("zero_ffv_a", 32'(ffv_a), 32'h03);
        check("zero_sat_b", 32'(err_b), 32'd15);

        sweep(M_ONE, M_ONE, 8'hFF);
        check("one_err_a", 32'(err_a), 32'd132);
        check("one_ffv_a", 32'(ffv_a), 32'h00);

        sweep(M_INV, M_INV, 8'hFF);
        check("inv_err_a", 32'(err_a), 32'd256);
        check("inv_sat_b", 32'(err_b), 32'd15);

        sweep(M_EXTRA, M_OK, 8'hFF);
        check("extra_fail_a", 32'({pass_a, err_a != 9'd0}), 32'({1'b0, 1'b1}));
        check("extra_pass_b", 32'(pass_b), 32'd1);

        // Asynchronous abort mid-sweep: no scoreboard entry, so any done pulse is flagged.
        mode_a = M_ZERO;
        mode_b = M_ZERO;
        pulse_start();
        n = 0;
        while (vec_a != 8'h80 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("reach_0x80", 32'(n < 400), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_a", 32'({busy_a, done_a, vec_a, pass_a, err_a, ffv_a, ffval_a}), 32'd0);
        check("abort_b", 32'({busy_b, done_b, vec_b, pass_b, err_b, ffv_b, ffval_b}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_stays_idle", 32'({busy_a, busy_b}), 32'd0);

        sweep(M_OK, M_OK, 8'h00);

        // start held high: back-to-back sweeps with one DONE and one IDLE cycle between them.
        mode_a = M_ZERO;
        mode_b = M_ZERO;
        q_a.push_back(model(M_ZERO, 1, 8'hFF, 9));
        q_b.push_back(model(M_ZERO, 2, 8'hFF, 4));
        @(negedge clk);
        start = 1'b1;
        wait_done(0);
        mode_a = M_OK;
        q_a.push_back(model(M_OK, 1, 8'hFF, 9));
        @(negedge clk);
        check("b2b_idle_gap_a", 32'({busy_a, done_a}), 32'd0);
        wait_done(1);
        mode_b = M_OK;
        q_b.push_back(model(M_OK, 2, 8'hFF, 4));
        @(negedge clk);
        check("b2b_restart_a", 32'({busy_a, vec_a}), 32'({1'b1, 8'h00}));
        check("b2b_cleared_a", 32'({pass_a, err_a, ffval_a}), 32'd0);
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        check("sb_drained_a", 32'(q_a.size()), 32'd0);
        check("sb_drained_b", 32'(q_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/function8bit_bist.md
Name: function8bit_bist

Overview:
Exhaustive self-test driver and checker for the registered 8-input boolean function block. It drives all 256 input vectors onto the function block's a..h inputs. It takes the registered y output back and compares it against an internal golden model, after aligning for the block's pipeline latency. It sits beside the function block in test builds and reports pass/fail, an error count and the first failing vector.

Parameters:
LATENCY, 1, clock cycles from vec_out change to the corresponding dut_y; legal range 1..4
ERR_CNT_W, 9, width of err_count; the count saturates at 2^ERR_CNT_W-1

Ports:
clk  input  1  rising-edge clock shared with the function block
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse when the sweep has fully completed
vec_out  output  8  stimulus vector; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=h
dut_y  input  1  y returned from the function block
pass  output  1  high when the last completed sweep had zero mismatches
err_count  output  ERR_CNT_W  mismatches in the current or last sweep
first_fail_vec  output  8  vector of the first mismatch
first_fail_valid  output  1  first_fail_vec holds a captured value

Behaviour:
- Reset (rst_n low, asynchronous) puts the block in IDLE with every output at 0: busy, done, vec_out, pass, err_count, first_fail_vec, first_fail_valid. It also clears the tag pipeline.
- Golden model: exp = ((a&b)|c) ^ ((d&e)|f) ^ (g&h), computed combinationally from vec_out.
- Tag pipeline: LATENCY stages, each holding {valid, exp, vec}.
  - Stage 0 loads {state==RUN, exp(vec_out), vec_out} every cycle.
  - The compare happens at the last stage when its valid bit is 1: mismatch = (dut_y != exp_tag).
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: when start=1, go to RUN at the next edge. On that same edge set vec_out=0, clear err_count, first_fail_valid and pass, and clear the tag valids.
  - RUN: vec_out increments by 1 each cycle. When vec_out==8'hFF, go to DRAIN; vec_out holds at 8'hFF.
  - DRAIN: stays LATENCY cycles, tracked by a drain counter, so the last tagged vector is compared. Then go to DONE.
  - DONE: done=1 for exactly one cycle and pass <= (err_count==0) after the final compare. Go to IDLE next cycle.
- start is ignored in RUN, DRAIN and DONE. No queued restart.
- Cycle timing, with start sampled at edge 0:
  - vec_out = k during cycle k+1, for k = 0..255.
  - done is high in cycle 257+LATENCY.
  - busy is high in cycles 1..256+LATENCY.
- err_count increments by 1 per mismatch and saturates at all-ones with no wrap.
- On the first mismatch of a sweep, first_fail_vec <= vec_tag and first_fail_valid <= 1. Later mismatches do not overwrite it.
- Results (pass, err_count, first_fail_*) hold after DONE until the next accepted start or reset.
- Reset asserted mid-sweep aborts immediately to reset values. No done pulse is produced. The next sweep needs a new start.
- vec_out is registered. There is no combinational path from dut_y to any output.

Test Plan:
- Correct function block in loop, LATENCY=1, start pulsed one cycle -> vec_out walks 0x00..0xFF, done in cycle 258, pass=1, err_count=0, first_fail_valid=0.
- dut_y tied to 0 -> err_count=124 (124 of the 256 vectors give golden 1), pass=0, first_fail_vec=0x03.
- dut_y tied to 1 -> err_count=132, first_fail_vec=0x00. dut_y driven as the inverted correct output -> err_count=256. With ERR_CNT_W=4, err_count saturates at 15.
- Correct block with an extra register inserted and LATENCY=2 -> pass=1, done in cycle 259. Same DUT with LATENCY=1 -> pass=0, nonzero err_count.
- rst_n pulsed low while vec_out=0x80 -> all outputs 0 asynchronously, no done pulse. start asserted while busy -> ignored. A new start afterwards runs a full clean sweep with pass=1.
- start held high continuously -> back-to-back sweeps, each separated by the one DONE cycle and one IDLE cycle. Results clear at each new sweep.
